vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA raster timing generator: cascaded horizontal/vertical counters with phase decode.
//  Produces hsync, vsync, data-enable, pixel coordinates and line/frame strobes for the pixel pipeline.
//  Sits between the pixel-clock domain source and the pattern/framebuffer read logic.
//  Generalises the fixed two-counter pulse generator to full porch/sync timing, polarity, restart and stall.
// PARAMETERS
//  H_ACTIVE   640  visible pixels per line
//  H_FP       16   horizontal front porch, pixels
//  H_SYNC     96   horizontal sync width, pixels
//  H_BP       48   horizontal back porch, pixels
//  V_ACTIVE   480  visible lines per frame
//  V_FP       10   vertical front porch, lines
//  V_SYNC     2    vertical sync width, lines
//  V_BP       33   vertical back porch, lines
//  H_POL      0    hsync active level (0 = active-low)
//  V_POL      0    vsync active level (0 = active-low)
//  WIDTH      10   counter/coordinate width; must satisfy 2**WIDTH >= H_TOTAL and >= V_TOTAL
// PORTS
//  clk          in   1      pixel clock, all logic on rising edge
//  rst          in   1      asynchronous reset, active-low
//  cen          in   1      pixel enable; state advances only on clk edges with cen=1
//  restart      in   1      synchronous frame restart; overrides cen
//  hsync        out  1      horizontal sync, level per H_POL
//  vsync        out  1      vertical sync, level per V_POL
//  de           out  1      1 when (x,y) is inside the active area
//  x            out  WIDTH  horizontal count 0..H_TOTAL-1
//  y            out  WIDTH  vertical count 0..V_TOTAL-1
//  line_start   out  1      1-cycle strobe when x==0
//  frame_start  out  1      1-cycle strobe when x==0 and y==0
// BEHAVIOUR
//  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Phase order per axis: ACTIVE,FP,SYNC,BP.
//  - Per-axis phase FSM ACTIVE->FP->SYNC->BP->ACTIVE, advancing when the counter reaches the last
//    count of the current phase; hsync asserted only in H SYNC, vsync only in V SYNC (whole lines).
//  - Two stages: counter stage (h_cnt,v_cnt) and registered output stage. On each clk edge with cen=1:
//    output regs <= decode(h_cnt,v_cnt); h_cnt <= next. Outputs lag the counters by exactly one cen.
//  - h_cnt wraps H_TOTAL-1 -> 0; v_cnt increments only on that wrap; v_cnt wraps V_TOTAL-1 -> 0
//    on the same edge as the h wrap (simultaneous wrap: both to 0, no skipped/duplicated line).
//  - cen=0: counters and all outputs hold; strobes that are high remain high (held, not re-pulsed
//    as new events) until the next cen edge.
//  - de = (x < H_ACTIVE) && (y < V_ACTIVE); x,y, sync and de always mutually consistent in a cycle.
//  - Reset (rst=0, asynchronous): h_cnt=v_cnt=0; x=y=0; de=0; line_start=frame_start=0;
//    hsync=~H_POL; vsync=~V_POL. First cen edge after release gives x=0,y=0,de=1,
//    line_start=1,frame_start=1.
//  - restart=1 on a clk edge (cen ignored): counters <= 0, outputs <= reset values; behaves
//    exactly like reset release thereafter. Mid-frame restart is legal; no partial sync pulse extended.
//  - Async reset mid-line: outputs go to reset values immediately, not on the next edge.
//  - All arithmetic unsigned WIDTH bits; phase boundaries are elaboration-time constants.
// TESTING
//  - Defaults, cen=1: hsync low exactly for x=656..751 (96 clk), line period 800 clk.
//  - Defaults: vsync low for y=490..491 (1600 clk), frame period 420000 clk, one frame_start per frame.
//  - Wrap: at x=799,y=524 next cen -> x=0,y=0,frame_start=1,de=1; y never reads 525.
//  - cen toggled 1/0 each clk: all outputs hold on cen=0, frame period becomes 840000 clk.
//  - restart at x=700,y=300 (cen=0) -> next edge outputs reset values, next cen x=0,y=0,frame_start=1.
//  - H_POL=1,V_POL=1 with 800x600 timing (40/128/88, 1/4/23) -> hsync high x=840..967, 1056-clk lines.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: cascaded h/v counters with per-axis phase FSMs
// and a registered decode stage for sync, data-enable, coordinates and strobes.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned H_POL    = 0,
    parameter int unsigned V_POL    = 0,
    parameter int unsigned WIDTH    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             restart,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             line_start,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_END_ACT  = H_ACTIVE - 1;
    localparam int unsigned H_END_FP   = H_ACTIVE + H_FP - 1;
    localparam int unsigned H_END_SYNC = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int unsigned H_END_BP   = H_TOTAL - 1;
    localparam int unsigned V_END_ACT  = V_ACTIVE - 1;
    localparam int unsigned V_END_FP   = V_ACTIVE + V_FP - 1;
    localparam int unsigned V_END_SYNC = V_ACTIVE + V_FP + V_SYNC - 1;
    localparam int unsigned V_END_BP   = V_TOTAL - 1;

    localparam logic HS_ON  = 1'(H_POL);
    localparam logic HS_OFF = ~HS_ON;
    localparam logic VS_ON  = 1'(V_POL);
    localparam logic VS_OFF = ~VS_ON;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_t;

    phase_t           h_phase, h_phase_nxt;
    phase_t           v_phase, v_phase_nxt;
    logic [WIDTH-1:0] h_cnt, h_cnt_nxt;
    logic [WIDTH-1:0] v_cnt, v_cnt_nxt;
    logic             h_wrap;

    // Counter/phase state; restart has priority over the pixel enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_phase <= PH_ACTIVE;
            v_phase <= PH_ACTIVE;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else if (restart) begin
            h_phase <= PH_ACTIVE;
            v_phase <= PH_ACTIVE;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else if (cen) begin
            h_phase <= h_phase_nxt;
            v_phase <= v_phase_nxt;
            h_cnt   <= h_cnt_nxt;
            v_cnt   <= v_cnt_nxt;
        end
    end

    // Horizontal phase advance on the last count of each phase
    always_comb begin
        h_phase_nxt = h_phase;
        h_wrap      = (h_cnt == WIDTH'(H_END_BP));
        h_cnt_nxt   = h_wrap ? '0 : h_cnt + WIDTH'(1);
        case (h_phase)
            PH_ACTIVE: if (h_cnt == WIDTH'(H_END_ACT))  h_phase_nxt = PH_FP;
            PH_FP:     if (h_cnt == WIDTH'(H_END_FP))   h_phase_nxt = PH_SYNC;
            PH_SYNC:   if (h_cnt == WIDTH'(H_END_SYNC)) h_phase_nxt = PH_BP;
            PH_BP:     if (h_wrap)                      h_phase_nxt = PH_ACTIVE;
            default:                                    h_phase_nxt = PH_ACTIVE;
        endcase
    end

    // Vertical axis moves only on the horizontal wrap, so both wrap on one edge
    always_comb begin
        v_phase_nxt = v_phase;
        v_cnt_nxt   = v_cnt;
        if (h_wrap) begin
            v_cnt_nxt = (v_cnt == WIDTH'(V_END_BP)) ? '0 : v_cnt + WIDTH'(1);
            case (v_phase)
                PH_ACTIVE: if (v_cnt == WIDTH'(V_END_ACT))  v_phase_nxt = PH_FP;
                PH_FP:     if (v_cnt == WIDTH'(V_END_FP))   v_phase_nxt = PH_SYNC;
                PH_SYNC:   if (v_cnt == WIDTH'(V_END_SYNC)) v_phase_nxt = PH_BP;
                PH_BP:     if (v_cnt == WIDTH'(V_END_BP))   v_phase_nxt = PH_ACTIVE;
                default:                                    v_phase_nxt = PH_ACTIVE;
            endcase
        end
    end

    // Output stage: one cen behind the counters, decoded from the same snapshot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync       <= HS_OFF;
            vsync       <= VS_OFF;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (restart) begin
            hsync       <= HS_OFF;
            vsync       <= VS_OFF;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (cen) begin
            hsync       <= (h_phase == PH_SYNC) ? HS_ON : HS_OFF;
            vsync       <= (v_phase == PH_SYNC) ? VS_ON : VS_OFF;
            de          <= (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
            x           <= h_cnt;
            y           <= v_cnt;
            line_start  <= (h_cnt == '0);
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480, 800x600 positive-polarity
// and a tiny-timing instance that makes full frames cheap to walk.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst;
    logic cen;
    logic restart;

    always #5 clk = ~clk;

    logic        d_hs, d_vs, d_de, d_ls, d_fs;
    logic [9:0]  d_x, d_y;
    logic        s_hs, s_vs, s_de, s_ls, s_fs;
    logic [10:0] s_x, s_y;
    logic        m_hs, m_vs, m_de, m_ls, m_fs;
    logic [3:0]  m_x, m_y;

    int checks = 0;
    int passed = 0;

    vga_timing_gen u_dut (
        .clk(clk), .rst(rst), .cen(cen), .restart(restart),
        .hsync(d_hs), .vsync(d_vs), .de(d_de), .x(d_x), .y(d_y),
        .line_start(d_ls), .frame_start(d_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
        .H_POL(1), .V_POL(1), .WIDTH(11)
    ) u_svga (
        .clk(clk), .rst(rst), .cen(cen), .restart(restart),
        .hsync(s_hs), .vsync(s_vs), .de(s_de), .x(s_x), .y(s_y),
        .line_start(s_ls), .frame_start(s_fs)
    );

    // H total 14, V total 8, vsync on lines 5..6
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(0), .V_POL(0), .WIDTH(4)
    ) u_small (
        .clk(clk), .rst(rst), .cen(cen), .restart(restart),
        .hsync(m_hs), .vsync(m_vs), .de(m_de), .x(m_x), .y(m_y),
        .line_start(m_ls), .frame_start(m_fs)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cen = 1'b0; restart = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({d_x, d_y, d_de, d_hs, d_vs, d_ls, d_fs} !== {10'd0, 10'd0, 5'b01100})
            $display("FAIL reset_default: got x=%0d y=%0d de/hs/vs/ls/fs=%b%b%b%b%b want 0 0 01100",
                     d_x, d_y, d_de, d_hs, d_vs, d_ls, d_fs);
        else passed++;
        checks++;
        if ({s_hs, s_vs, s_de} !== 3'b000)
            $display("FAIL reset_pol: got hs/vs/de=%b%b%b want 000", s_hs, s_vs, s_de);
        else passed++;
        cen = 1'b1;
        step(); step();
        checks++;
        if ({d_x, d_de, d_fs} !== {10'd0, 2'b00})
            $display("FAIL reset_held: got x=%0d de=%b fs=%b want 0 0 0", d_x, d_de, d_fs);
        else passed++;
        #2 rst = 1'b1;
        step();
        checks++;
        if ({d_x, d_y, d_de, d_hs, d_vs, d_ls, d_fs} !== {10'd0, 10'd0, 5'b11111})
            $display("FAIL first_edge: got x=%0d y=%0d de/hs/vs/ls/fs=%b%b%b%b%b want 0 0 11111",
                     d_x, d_y, d_de, d_hs, d_vs, d_ls, d_fs);
        else passed++;
        step();
        checks++;
        if ({d_x, d_ls, d_fs, d_de} !== {10'd1, 3'b001})
            $display("FAIL second_edge: got x=%0d ls=%b fs=%b de=%b want 1 0 0 1", d_x, d_ls, d_fs, d_de);
        else passed++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 10; i++) step();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({d_x, d_de, d_hs, d_ls} !== {10'd0, 3'b010})
            $display("FAIL async_reset: got x=%0d de=%b hs=%b ls=%b want 0 0 1 0", d_x, d_de, d_hs, d_ls);
        else passed++;
        rst = 1'b1;
        step();
        checks++;
        if ({d_x, d_y, d_fs, d_de} !== {10'd0, 10'd0, 2'b11})
            $display("FAIL async_release: got x=%0d y=%0d fs=%b de=%b want 0 0 1 1", d_x, d_y, d_fs, d_de);
        else passed++;
    endtask

    task automatic test_hline_default();
        int lo_cnt = 0, lo_first = -1, lo_last = -1, errs = 0;
        cen = 1'b1;
        do_restart();
        for (int i = 0; i < 800; i++) begin
            step();
            if (int'(d_x) != i || d_y != 10'd0) errs++;
            if (d_de !== (i < 640)) errs++;
            if (d_ls !== (i == 0)) errs++;
            if (d_hs === 1'b0) begin
                lo_cnt++;
                if (lo_first < 0) lo_first = i;
                lo_last = i;
            end
        end
        checks++;
        if (lo_cnt != 96 || lo_first != 656 || lo_last != 751)
            $display("FAIL hsync_window: got %0d clk x=%0d..%0d want 96 clk x=656..751", lo_cnt, lo_first, lo_last);
        else passed++;
        checks++;
        if (errs != 0)
            $display("FAIL hline_seq: got %0d x/de/ls errors want 0", errs);
        else passed++;
        step();
        checks++;
        if ({d_x, d_y, d_ls, d_fs, d_vs} !== {10'd0, 10'd1, 3'b101})
            $display("FAIL line_period: got x=%0d y=%0d ls=%b fs=%b vs=%b want 0 1 1 0 1",
                     d_x, d_y, d_ls, d_fs, d_vs);
        else passed++;
    endtask

    task automatic test_svga_line();
        int hi_cnt = 0, hi_first = -1, hi_last = -1, errs = 0;
        cen = 1'b1;
        do_restart();
        for (int i = 0; i < 1056; i++) begin
            step();
            if (int'(s_x) != i) errs++;
            if (s_de !== (i < 800)) errs++;
            if (s_vs !== 1'b0) errs++;
            if (s_hs === 1'b1) begin
                hi_cnt++;
                if (hi_first < 0) hi_first = i;
                hi_last = i;
            end
        end
        checks++;
        if (hi_cnt != 128 || hi_first != 840 || hi_last != 967)
            $display("FAIL svga_hsync: got %0d clk x=%0d..%0d want 128 clk x=840..967", hi_cnt, hi_first, hi_last);
        else passed++;
        checks++;
        if (errs != 0)
            $display("FAIL svga_seq: got %0d errors want 0", errs);
        else passed++;
        step();
        checks++;
        if ({s_x, s_y, s_ls} !== {11'd0, 11'd1, 1'b1})
            $display("FAIL svga_period: got x=%0d y=%0d ls=%b want 0 1 1", s_x, s_y, s_ls);
        else passed++;
    endtask

    task automatic test_frame_small();
        int errs = 0, vs_lo = 0, fs_cnt = 0, ex, ey;
        cen = 1'b1;
        do_restart();
        for (int i = 0; i <= 224; i++) begin
            step();
            ex = i % 14;
            ey = (i / 14) % 8;
            if (int'(m_x) != ex || int'(m_y) != ey) errs++;
            if (m_de !== (ex < 8 && ey < 4)) errs++;
            if (m_vs !== !(ey == 5 || ey == 6)) errs++;
            if (m_fs !== (ex == 0 && ey == 0)) errs++;
            if (m_vs === 1'b0) vs_lo++;
            if (m_fs === 1'b1) fs_cnt++;
            if (i == 111) begin
                checks++;
                if ({m_x, m_y} !== {4'd13, 4'd7})
                    $display("FAIL pre_wrap: got x=%0d y=%0d want 13 7", m_x, m_y);
                else passed++;
            end
            if (i == 112) begin
                checks++;
                if ({m_x, m_y, m_fs, m_de, m_ls} !== {4'd0, 4'd0, 3'b111})
                    $display("FAIL frame_wrap: got x=%0d y=%0d fs=%b de=%b ls=%b want 0 0 1 1 1",
                             m_x, m_y, m_fs, m_de, m_ls);
                else passed++;
            end
        end
        checks++;
        if (errs != 0)
            $display("FAIL frame_seq: got %0d errors want 0", errs);
        else passed++;
        checks++;
        if (vs_lo != 56 || fs_cnt != 3)
            $display("FAIL vsync_frames: got vs_low=%0d fs=%0d want 56 3", vs_lo, fs_cnt);
        else passed++;
    endtask

    task automatic test_cen_toggle();
        int n = 0, errs = 0, ex, ey, rise0 = -1, rise1 = -1;
        logic prev_fs = 1'b0;
        cen = 1'b0;
        do_restart();
        for (int i = 0; i < 460; i++) begin
            cen = (i % 2 == 0);
            step();
            if (cen) n++;
            ex = (n - 1) % 14;
            ey = ((n - 1) / 14) % 8;
            if (int'(m_x) != ex || int'(m_y) != ey) errs++;
            if (m_fs !== (ex == 0 && ey == 0)) errs++;
            if (m_ls !== (ex == 0)) errs++;
            if (m_fs === 1'b1 && prev_fs !== 1'b1) begin
                if (rise0 < 0) rise0 = i;
                else if (rise1 < 0) rise1 = i;
            end
            prev_fs = m_fs;
        end
        cen = 1'b1;
        checks++;
        if (errs != 0)
            $display("FAIL cen_hold: got %0d errors want 0", errs);
        else passed++;
        checks++;
        if (rise1 - rise0 != 224)
            $display("FAIL cen_period: got %0d clk want 224", rise1 - rise0);
        else passed++;
    endtask

    task automatic test_restart();
        cen = 1'b1;
        do_restart();
        for (int i = 0; i < 701; i++) step();
        checks++;
        if ({d_x, d_hs} !== {10'd700, 1'b0})
            $display("FAIL pre_restart: got x=%0d hs=%b want 700 0", d_x, d_hs);
        else passed++;
        cen = 1'b0;
        restart = 1'b1;
        step();
        restart = 1'b0;
        checks++;
        if ({d_x, d_y, d_de, d_hs, d_vs, d_ls, d_fs} !== {10'd0, 10'd0, 5'b01100})
            $display("FAIL restart_vals: got x=%0d y=%0d de/hs/vs/ls/fs=%b%b%b%b%b want 0 0 01100",
                     d_x, d_y, d_de, d_hs, d_vs, d_ls, d_fs);
        else passed++;
        step();
        cen = 1'b1;
        step();
        checks++;
        if ({d_x, d_y, d_fs, d_de, d_ls} !== {10'd0, 10'd0, 3'b111})
            $display("FAIL restart_first: got x=%0d y=%0d fs=%b de=%b ls=%b want 0 0 1 1 1",
                     d_x, d_y, d_fs, d_de, d_ls);
        else passed++;
        step();
        checks++;
        if ({d_x, d_fs} !== {10'd1, 1'b0})
            $display("FAIL restart_next: got x=%0d fs=%b want 1 0", d_x, d_fs);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_hline_default();
        test_svga_line();
        test_frame_small();
        test_cen_toggle();
        test_restart();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
